// File: rtl/drum_pkg.sv
// Shared definitions for the drum mesh column engine: default widths,
// sequencer state encoding and the signed node value type.
package drum_pkg;

  localparam int ROWS_DEF   = 30;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 18;

  // Sequencer states: init walk, step preamble, then four phases per row.
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PRE_RD,
    S_PRE_WT,
    S_RD,
    S_WT,
    S_CALC,
    S_WB
  } state_e;

  // Node value, signed 1.17 fixed point.
  typedef logic signed [DATA_W_DEF-1:0] node_t;

endpackage

// File: rtl/drum_col_ram.sv
// One column of node values: 1 read / 1 write synchronous RAM with a
// registered read port, shaped for block-RAM inference.
module drum_col_ram #(
  parameter int DEPTH  = 30,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 18
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port and registered read port.
  // NOTE: the array and read register have no reset; a reset would stop the
  // tools mapping this onto a block RAM, and the column is reloaded by init.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[wr_addr_i] <= wr_data_i;
    if (re_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/drum_column_engine.sv
// Row sequencer for one column of the 2-D drum mesh. Walks the rows once
// per time step, feeds registered operands to an external node calculator
// and writes u(n+1) / u(n) back into the two column RAMs.
// Optional feature: define DRUM_CENTER_TAP_EN to keep the latest u(n+1)
// of the centre row on center_out; otherwise center_out is tied to 0.
module drum_column_engine
  import drum_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic              start,
  input  logic [DATA_W-1:0] hit_amp,
  input  logic [DATA_W-1:0] rho_in,
  input  logic [DATA_W-1:0] u_left_in,
  input  logic [DATA_W-1:0] u_right_in,
  output logic [DATA_W-1:0] u_mid_out,
  output logic [ADDR_W-1:0] row_idx,
  output logic [DATA_W-1:0] nd_u_1_mid,
  output logic [DATA_W-1:0] nd_u_1_up,
  output logic [DATA_W-1:0] nd_u_1_down,
  output logic [DATA_W-1:0] nd_u_1_left,
  output logic [DATA_W-1:0] nd_u_1_right,
  output logic [DATA_W-1:0] nd_u_0_mid,
  output logic [DATA_W-1:0] nd_rho,
  input  logic [DATA_W-1:0] nd_u_2_mid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] center_out
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CENTER = ADDR_W'(ROWS / 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [DATA_W-1:0] mid_q, mid_d, up_q, up_d, down_q, down_d;
  logic [DATA_W-1:0] prev_q, prev_d, rho_q, rho_d;
  logic [DATA_W-1:0] nd_mid_q, nd_mid_d, nd_up_q, nd_up_d, nd_down_q, nd_down_d;
  logic [DATA_W-1:0] nd_left_q, nd_left_d, nd_right_q, nd_right_d;
  logic [DATA_W-1:0] nd_prev_q, nd_prev_d, nd_rho_q, nd_rho_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              curr_we, curr_re, prev_we, prev_re;
  logic [ADDR_W-1:0] curr_ra, prev_ra;
  logic [DATA_W-1:0] curr_wd, prev_wd, curr_rd, prev_rd;

  drum_col_ram #(.DEPTH(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_curr_ram (
    .clk_i(clock), .we_i(curr_we), .wr_addr_i(row_q), .wr_data_i(curr_wd),
    .re_i(curr_re), .rd_addr_i(curr_ra), .rd_data_o(curr_rd)
  );

  drum_col_ram #(.DEPTH(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prev_ram (
    .clk_i(clock), .we_i(prev_we), .wr_addr_i(row_q), .wr_data_i(prev_wd),
    .re_i(prev_re), .rd_addr_i(prev_ra), .rd_data_o(prev_rd)
  );

  // Next-state, datapath register loads and RAM controls.
  // NOTE: every signal gets its default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    mid_d      = mid_q;
    up_d       = up_q;
    down_d     = down_q;
    prev_d     = prev_q;
    rho_d      = rho_q;
    nd_mid_d   = nd_mid_q;
    nd_up_d    = nd_up_q;
    nd_down_d  = nd_down_q;
    nd_left_d  = nd_left_q;
    nd_right_d = nd_right_q;
    nd_prev_d  = nd_prev_q;
    nd_rho_d   = nd_rho_q;
    done_d     = 1'b0;
    curr_we    = 1'b0;
    prev_we    = 1'b0;
    curr_wd    = '0;
    prev_wd    = '0;
    curr_re    = 1'b0;
    prev_re    = 1'b0;
    curr_ra    = row_q + ADDR_W'(1);
    prev_ra    = row_q;

    unique case (state_q)
      S_IDLE: begin
        // busy stays high through the done cycle, so requests there are dropped
        if (!busy_q) begin
          if (init) begin
            state_d = S_INIT;
            row_d   = '0;
          end else if (start) begin
            state_d = S_PRE_RD;
            row_d   = '0;
            rho_d   = rho_in;
          end
        end
      end
      S_INIT: begin
        curr_we = 1'b1;
        prev_we = 1'b1;
        curr_wd = (row_q == CENTER) ? hit_amp : '0;
        prev_wd = curr_wd;
        if (row_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + ADDR_W'(1);
        end
      end
      S_PRE_RD: begin
        curr_re = 1'b1;
        curr_ra = '0;
        state_d = S_PRE_WT;
      end
      S_PRE_WT: begin
        mid_d   = curr_rd;
        down_d  = '0;
        state_d = S_RD;
      end
      S_RD: begin
        // the row above the top edge does not exist; its value is forced to 0
        curr_re = (row_q != LAST);
        prev_re = 1'b1;
        state_d = S_WT;
      end
      S_WT: begin
        up_d    = (row_q == LAST) ? '0 : curr_rd;
        prev_d  = prev_rd;
        state_d = S_CALC;
      end
      S_CALC: begin
        nd_mid_d   = mid_q;
        nd_up_d    = up_q;
        nd_down_d  = down_q;
        nd_left_d  = u_left_in;
        nd_right_d = u_right_in;
        nd_prev_d  = prev_q;
        nd_rho_d   = rho_q;
        state_d    = S_WB;
      end
      S_WB: begin
        // the shift registers keep pre-step u(n) so later rows see old neighbours
        curr_we = 1'b1;
        curr_wd = nd_u_2_mid;
        prev_we = 1'b1;
        prev_wd = mid_q;
        down_d  = mid_q;
        mid_d   = up_q;
        if (row_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          row_d   = row_q + ADDR_W'(1);
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and datapath registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      mid_q      <= '0;
      up_q       <= '0;
      down_q     <= '0;
      prev_q     <= '0;
      rho_q      <= '0;
      nd_mid_q   <= '0;
      nd_up_q    <= '0;
      nd_down_q  <= '0;
      nd_left_q  <= '0;
      nd_right_q <= '0;
      nd_prev_q  <= '0;
      nd_rho_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      mid_q      <= mid_d;
      up_q       <= up_d;
      down_q     <= down_d;
      prev_q     <= prev_d;
      rho_q      <= rho_d;
      nd_mid_q   <= nd_mid_d;
      nd_up_q    <= nd_up_d;
      nd_down_q  <= nd_down_d;
      nd_left_q  <= nd_left_d;
      nd_right_q <= nd_right_d;
      nd_prev_q  <= nd_prev_d;
      nd_rho_q   <= nd_rho_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef DRUM_CENTER_TAP_EN
  logic [DATA_W-1:0] center_q, center_d;

  // Centre tap: loaded by init, refreshed when the centre row is written back.
  always_comb begin
    center_d = center_q;
    if (state_q == S_INIT && row_q == CENTER)    center_d = hit_amp;
    else if (state_q == S_WB && row_q == CENTER) center_d = nd_u_2_mid;
  end

  // Centre tap register.
  always_ff @(posedge clock) begin
    if (!reset) center_q <= '0;
    else        center_q <= center_d;
  end

  assign center_out = center_q;
`else
  assign center_out = '0;
`endif

  assign u_mid_out    = mid_q;
  assign row_idx      = row_q;
  assign nd_u_1_mid   = nd_mid_q;
  assign nd_u_1_up    = nd_up_q;
  assign nd_u_1_down  = nd_down_q;
  assign nd_u_1_left  = nd_left_q;
  assign nd_u_1_right = nd_right_q;
  assign nd_u_0_mid   = nd_prev_q;
  assign nd_rho       = nd_rho_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_drum_column_engine.sv
// Self-checking bench for drum_column_engine with ROWS=4. A stub node
// calculator closes the loop; a column model (arrays of u(n), u(n-1))
// predicts every operand the engine presents and the centre tap value.
module tb_drum_column_engine;

  localparam int ROWS   = 4;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 18;
  localparam int LAT    = 2 + 4 * ROWS;
`ifdef DRUM_CENTER_TAP_EN
  localparam bit TAP = 1'b1;
`else
  localparam bit TAP = 1'b0;
`endif

  typedef logic [DATA_W-1:0] word_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              init  = 1'b0;
  logic              start = 1'b0;
  word_t             hit_amp = '0, rho_in = '0, u_left_in = '0, u_right_in = '0;
  word_t             u_mid_out, nd_u_1_mid, nd_u_1_up, nd_u_1_down, nd_u_1_left;
  word_t             nd_u_1_right, nd_u_0_mid, nd_rho, nd_u_2_mid, center_out;
  logic [ADDR_W-1:0] row_idx;
  logic              busy, done;

  // Stub node calculator: mid + up, or a forced constant for shaping the column.
  logic  stub_mode  = 1'b0;
  word_t stub_const = '0;
  assign nd_u_2_mid = stub_mode ? stub_const : word_t'(nd_u_1_mid + nd_u_1_up);

  drum_column_engine #(.ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .init(init), .start(start),
    .hit_amp(hit_amp), .rho_in(rho_in), .u_left_in(u_left_in), .u_right_in(u_right_in),
    .u_mid_out(u_mid_out), .row_idx(row_idx),
    .nd_u_1_mid(nd_u_1_mid), .nd_u_1_up(nd_u_1_up), .nd_u_1_down(nd_u_1_down),
    .nd_u_1_left(nd_u_1_left), .nd_u_1_right(nd_u_1_right), .nd_u_0_mid(nd_u_0_mid),
    .nd_rho(nd_rho), .nd_u_2_mid(nd_u_2_mid), .busy(busy), .done(done),
    .center_out(center_out)
  );

  always #5 clock = ~clock;

  // Column model: u(n) and u(n-1) per row, plus the expected centre tap.
  word_t cur [ROWS];
  word_t prv [ROWS];
  word_t ctr = '0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic test_reset();
    logic [7*DATA_W-1:0] nd_all;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    nd_all = {nd_u_1_mid, nd_u_1_up, nd_u_1_down, nd_u_1_left, nd_u_1_right, nd_u_0_mid, nd_rho};
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (nd_all !== '0) begin n_bad++; $display("FAIL reset_nd: got %h expected 0", nd_all); end
    n_cmp++; if ({u_mid_out, row_idx, center_out} !== '0) begin
      n_bad++; $display("FAIL reset_misc: got %h/%h/%h expected 0", u_mid_out, row_idx, center_out);
    end
    @(negedge clock) reset = 1'b1;
  endtask

  // Load a hit profile; also_start raises start in the same cycle as init.
  task automatic test_init(input word_t h, input logic also_start);
    int busy_n = 0, done_n = 0, done_at = -1;
    @(negedge clock);
    init = 1'b1; start = also_start; hit_amp = h;
    @(posedge clock); #1;
    init = 1'b0; start = 1'b0;
    for (int c = 1; c <= ROWS + 12; c++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin done_n++; done_at = c; end
      @(posedge clock); #1;
    end
    hit_amp = word_t'($urandom);
    for (int r = 0; r < ROWS; r++) begin
      cur[r] = (r == ROWS / 2) ? h : '0;
      prv[r] = cur[r];
    end
    if (TAP) ctr = h;
    n_cmp++; if (busy_n != ROWS + 1) begin n_bad++; $display("FAIL init_busy_cycles: got %0d expected %0d", busy_n, ROWS + 1); end
    n_cmp++; if (done_n != 1) begin n_bad++; $display("FAIL init_done_pulses: got %0d expected 1", done_n); end
    n_cmp++; if (done_at != ROWS + 1) begin n_bad++; $display("FAIL init_done_cycle: got %0d expected %0d", done_at, ROWS + 1); end
    n_cmp++; if (center_out !== (TAP ? ctr : '0)) begin
      n_bad++; $display("FAIL init_center: got %h expected %h", center_out, TAP ? ctr : '0);
    end
  endtask

  // One time step. poke raises start/init while busy; rst_row >= 0 pulls
  // reset low during write-back of that row and checks the abort.
  task automatic test_step(input word_t rho, input logic mode, input word_t cst,
                           input logic poke, input int rst_row);
    word_t nxt [ROWS];
    word_t act [7];
    word_t exp [7];
    string nm  [7];
    word_t lft, rgt;
    stub_mode = mode; stub_const = cst;
    @(negedge clock);
    start = 1'b1; rho_in = rho;
    @(posedge clock); #1;
    start = 1'b0; rho_in = word_t'($urandom);
    repeat (4) @(posedge clock);
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clock);
      lft = word_t'($urandom); rgt = word_t'($urandom);
      u_left_in = lft; u_right_in = rgt;
      if (poke && r == 1) begin start = 1'b1; init = 1'b1; end
      n_cmp++; if (u_mid_out !== cur[r]) begin n_bad++; $display("FAIL u_mid_out row %0d: got %h expected %h", r, u_mid_out, cur[r]); end
      n_cmp++; if (row_idx !== ADDR_W'(r)) begin n_bad++; $display("FAIL row_idx: got %0d expected %0d", row_idx, r); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL step_busy row %0d: got %b expected 1", r, busy); end
      @(posedge clock); #1;
      start = 1'b0; init = 1'b0;
      act = '{nd_u_1_mid, nd_u_1_up, nd_u_1_down, nd_u_1_left, nd_u_1_right, nd_u_0_mid, nd_rho};
      exp = '{cur[r], (r == ROWS - 1) ? '0 : cur[(r + 1) % ROWS], (r == 0) ? '0 : cur[(r + ROWS - 1) % ROWS],
              lft, rgt, prv[r], rho};
      nm  = '{"nd_u_1_mid", (r == ROWS - 1) ? "boundary_up_last" : "nd_u_1_up",
              (r == 0) ? "boundary_down_row0" : "nd_u_1_down",
              "nd_u_1_left", "nd_u_1_right", "nd_u_0_mid", "nd_rho"};
      for (int k = 0; k < 7; k++) begin
        n_cmp++;
        if (act[k] !== exp[k]) begin
          n_bad++; $display("FAIL %s row %0d: got %h expected %h", nm[k], r, act[k], exp[k]);
        end
      end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_early row %0d: got %b expected 0", r, done); end
      nxt[r] = mode ? cst : word_t'(exp[0] + exp[1]);
      u_left_in = word_t'($urandom); u_right_in = word_t'($urandom);
      if (r == rst_row) begin
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
          n_bad++; $display("FAIL abort_busy_done: got %b/%b expected 0/0", busy, done);
        end
        n_cmp++; if ({nd_u_1_mid, nd_u_1_up, nd_u_1_down, nd_u_1_left, nd_u_1_right, nd_u_0_mid, nd_rho} !== '0) begin
          n_bad++; $display("FAIL abort_nd: got %h expected 0", {nd_u_1_mid, nd_u_1_up, nd_u_0_mid, nd_rho});
        end
        n_cmp++; if ({u_mid_out, row_idx, center_out} !== '0) begin
          n_bad++; $display("FAIL abort_misc: got %h/%h/%h expected 0", u_mid_out, row_idx, center_out);
        end
        @(negedge clock) reset = 1'b1;
        ctr = '0;
        repeat (LAT) begin
          @(posedge clock); #1;
          n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_quiet: got done %b expected 0", done); end
        end
        return;
      end
      if (r < ROWS - 1) repeat (3) @(posedge clock);
    end
    @(posedge clock); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_latency_%0d: got %b expected 1", LAT, done); end
    for (int r = 0; r < ROWS; r++) begin
      prv[r] = cur[r];
      cur[r] = nxt[r];
    end
    if (TAP) ctr = nxt[ROWS / 2];
    n_cmp++; if (center_out !== (TAP ? ctr : '0)) begin
      n_bad++; $display("FAIL step_center: got %h expected %h", center_out, TAP ? ctr : '0);
    end
    if (poke) begin start = 1'b1; init = 1'b1; end
    @(posedge clock); #1;
    start = 1'b0; init = 1'b0;
    repeat (4) begin
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL after_done: got done %b busy %b expected 0/0", done, busy);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    // hit profile and the reference step from the stub calculator
    test_init(18'h04000, 1'b0);
    test_step(word_t'($urandom), 1'b0, '0, 1'b0, -1);
    // fill the column with 7s, then confirm the fixed edges
    test_step(word_t'($urandom), 1'b1, 18'd7, 1'b0, -1);
    test_step(word_t'($urandom), 1'b0, '0, 1'b0, -1);
    // start/init while busy are dropped; following step confirms the RAM
    test_init(18'h04000, 1'b0);
    test_step(word_t'($urandom), 1'b0, '0, 1'b1, -1);
    test_step(word_t'($urandom), 1'b0, '0, 1'b0, -1);
    // init and start together: only init runs
    test_init(word_t'($urandom), 1'b1);
    test_step(word_t'($urandom), 1'b0, '0, 1'b0, -1);
    // randomized profiles and stub behaviour
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) test_init(word_t'($urandom), 1'b0);
      test_step(word_t'($urandom), 1'($urandom_range(0, 1)), word_t'($urandom), 1'b0, -1);
    end
    // reset during write-back of row 1, then recover
    test_init(word_t'($urandom), 1'b0);
    test_step(word_t'($urandom), 1'b0, '0, 1'b0, 1);
    test_init(word_t'($urandom), 1'b0);
    test_step(word_t'($urandom), 1'b0, '0, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
